// File: rtl/beamscaler_wb_pkg.sv
// Shared definitions for the beam scaler Wishbone readout: register map,
// STATUS/pair bit positions, FSM state encoding and the pair packing helper.
package beamscaler_wb_pkg;

  localparam logic [6:0] STATUS_ADR  = 7'h00;
  localparam logic [6:0] CONTROL_ADR = 7'h01;
  localparam logic [6:0] SCALER_BASE = 7'h40;

  localparam int STATUS_NEW_BIT   = 16;
  localparam int STATUS_NSCAL_LSB = 24;
  localparam int PAIR_HI_LSB      = 16;
  localparam int TORN_BIT         = 31;

  typedef enum logic [2:0] {
    IDLE,
    REG_ACK,
    ADDR_LO,
    WAIT_LO,
    ADDR_HI,
    WAIT_HI,
    PAIR_ACK
  } state_t;

  // Scaler 2n in [11:0], scaler 2n+1 in [27:16], torn flag on top.
  function automatic logic [31:0] pack_pair(input logic [23:0] pair, input logic torn);
    logic [31:0] w;
    w = '0;
    w[11:0] = pair[11:0];
    w[PAIR_HI_LSB +: 12] = pair[23:12];
    w[TORN_BIT] = torn;
    return w;
  endfunction

endpackage

// File: rtl/beamscaler_pair_fetch.sv
// Sequences the two wrapper reads that make up one scaler pair, honouring the
// wrapper read latency, and flags a pair whose halves straddle a done pulse.
module beamscaler_pair_fetch
  import beamscaler_wb_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start,
  input  logic [5:0]  pair_idx,
  input  logic        abort,
  input  logic        set_done,
  output logic [6:0]  scal_adr,
  input  logic [11:0] scal_dat,
  output logic        fetch_done,
  output logic [23:0] pair,
  output logic        torn
);

  localparam int CW = $clog2(READ_LATENCY + 1);
  // The ADDR_HI cycle is itself the last low-half wait cycle, so WAIT_LO is one shorter.
  localparam logic [CW-1:0] LO_LAST = CW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
  localparam logic [CW-1:0] HI_LAST = CW'(READ_LATENCY - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [5:0]      idx_q;
  logic [11:0]     lo_q, hi_q;
  logic            torn_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
    state_nxt = state;
    if (state != IDLE && abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (start) state_nxt = ADDR_LO;
        ADDR_LO:  state_nxt = (READ_LATENCY > 1) ? WAIT_LO : ADDR_HI;
        WAIT_LO:  if (cnt == LO_LAST) state_nxt = ADDR_HI;
        ADDR_HI:  state_nxt = WAIT_HI;
        WAIT_HI:  if (cnt == HI_LAST) state_nxt = PAIR_ACK;
        PAIR_ACK: state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      scal_adr <= '0;
      cnt      <= '0;
      idx_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      torn_q   <= 1'b0;
    end else if (!abort) begin
      case (state)
        IDLE: if (start) idx_q <= pair_idx;
        ADDR_LO: begin
          scal_adr <= {idx_q, 1'b0};
          cnt      <= '0;
        end
        WAIT_LO: cnt <= cnt + 1'b1;
        ADDR_HI: begin
          lo_q     <= scal_dat;
          scal_adr <= {idx_q, 1'b1};
          torn_q   <= set_done;
          cnt      <= '0;
        end
        WAIT_HI: begin
          cnt    <= cnt + 1'b1;
          torn_q <= torn_q | set_done;
          if (cnt == HI_LAST) hi_q <= scal_dat;
        end
        default: ;
      endcase
    end
  end

  assign fetch_done = (state == PAIR_ACK);
  assign pair       = {hi_q, lo_q};
  assign torn       = torn_q;

endmodule

// File: rtl/beamscaler_wb_readout.sv
// Wishbone classic slave exposing STATUS/CONTROL and packed scaler pairs read
// from the beam scaler wrapper, with update counting and a level interrupt.
module beamscaler_wb_readout
  import beamscaler_wb_pkg::*;
#(
  parameter int NSCALERS     = 96,
  parameter int READ_LATENCY = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [6:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [6:0]  scal_adr_o,
  input  logic [11:0] scal_dat_i,
  input  logic        done_i,
  output logic        irq_o
);

  localparam int NPAIRS = NSCALERS / 2;

  state_t      state, state_nxt;
  logic [6:0]  pair_off;
  logic        accept, is_pair_rd, status_rd;
  logic [6:0]  adr_q;
  logic        we_q, wbit_q;
  logic [15:0] count;
  logic        new_data, irq_en;
  logic [31:0] reg_rdata;
  logic        fetch_done, fetch_torn;
  logic [23:0] fetch_pair;
  logic        unused_wdat;

  assign unused_wdat = ^wb_dat_i[31:1];

  assign pair_off   = wb_adr_i - SCALER_BASE;
  assign accept     = (state == IDLE) && wb_cyc_i && wb_stb_i && !wb_ack_o;
  assign is_pair_rd = !wb_we_i && (wb_adr_i >= SCALER_BASE) && (pair_off < 7'(NPAIRS));
  assign status_rd  = (state == REG_ACK) && wb_cyc_i && !we_q && (adr_q == STATUS_ADR);

  beamscaler_pair_fetch #(
    .READ_LATENCY(READ_LATENCY)
  ) u_fetch (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .start     (accept && is_pair_rd),
    .pair_idx  (pair_off[5:0]),
    .abort     (!wb_cyc_i),
    .set_done  (done_i),
    .scal_adr  (scal_adr_o),
    .scal_dat  (scal_dat_i),
    .fetch_done(fetch_done),
    .pair      (fetch_pair),
    .torn      (fetch_torn)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_nxt;
  end

  // PAIR_ACK spans the whole fetch here; the sub-module tracks the fine-grained phase.
  always_comb begin
    state_nxt = state;
    if (state != IDLE && !wb_cyc_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (accept) state_nxt = is_pair_rd ? PAIR_ACK : REG_ACK;
        REG_ACK:  state_nxt = IDLE;
        PAIR_ACK: if (fetch_done) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (adr_q)
      STATUS_ADR: begin
        reg_rdata[15:0]                 = count;
        reg_rdata[STATUS_NEW_BIT]       = new_data;
        reg_rdata[STATUS_NSCAL_LSB +: 8] = 8'(NSCALERS);
      end
      CONTROL_ADR: reg_rdata[0] = irq_en;
      default:     reg_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      adr_q    <= '0;
      we_q     <= 1'b0;
      wbit_q   <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      if (accept) begin
        adr_q  <= wb_adr_i;
        we_q   <= wb_we_i;
        wbit_q <= wb_dat_i[0];
      end
      if (state == REG_ACK && wb_cyc_i) begin
        wb_ack_o <= 1'b1;
        if (!we_q) wb_dat_o <= reg_rdata;
        if (we_q && adr_q == CONTROL_ADR) irq_en <= wbit_q;
      end
      if (state == PAIR_ACK && wb_cyc_i && fetch_done) begin
        wb_ack_o <= 1'b1;
        wb_dat_o <= pack_pair(fetch_pair, fetch_torn);
      end
    end
  end

  // A done pulse coinciding with the STATUS read ack wins over the clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      count    <= '0;
      new_data <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      if (done_i)         count <= count + 16'd1;
      if (done_i)         new_data <= 1'b1;
      else if (status_rd) new_data <= 1'b0;
      irq_o <= new_data & irq_en;
    end
  end

endmodule

// File: tb/tb_beamscaler_wb_readout.sv
// Directed bench for beamscaler_wb_readout with a one-stage wrapper model
// (READ_LATENCY=2) returning scaler value = address x 3.
module tb_beamscaler_wb_readout;

  logic        wb_clk_i  = 1'b0;
  logic        wb_rst_ni = 1'b1;
  logic        wb_cyc_i  = 1'b0;
  logic        wb_stb_i  = 1'b0;
  logic        wb_we_i   = 1'b0;
  logic [6:0]  wb_adr_i  = '0;
  logic [31:0] wb_dat_i  = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [6:0]  scal_adr_o;
  logic [11:0] scal_dat_i = '0;
  logic        done_i = 1'b0;
  logic        irq_o;

  int n_cmp = 0;
  int n_bad = 0;

  beamscaler_wb_readout #(
    .NSCALERS(96),
    .READ_LATENCY(2)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o),
    .scal_adr_o(scal_adr_o),
    .scal_dat_i(scal_dat_i),
    .done_i    (done_i),
    .irq_o     (irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Wrapper model: one register stage, so data is capturable two edges after an address change.
  always @(posedge wb_clk_i) scal_dat_i <= 12'(32'(scal_adr_o) * 3);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reads one word. done_at = k raises done_i for the edge k+1 counted from the
  // accept edge (k=0: the accept edge itself; -1: none). lat = edges from accept to ack.
  task automatic bus_read(input logic [6:0] a, input int done_at,
                          output logic [31:0] d, output int lat);
    @(negedge wb_clk_i);
    wb_adr_i = a; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    done_i = (done_at == 0);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge wb_clk_i); #1;
      done_i = (n == done_at);
      if (wb_ack_o) begin
        lat = n - 1;
        break;
      end
    end
    d = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; done_i = 1'b0;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic bus_write(input logic [6:0] a, input logic [31:0] v, output int lat);
    @(negedge wb_clk_i);
    wb_adr_i = a; wb_dat_i = v; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge wb_clk_i); #1;
      if (wb_ack_o) begin
        lat = n - 1;
        break;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic pulse_done();
    @(negedge wb_clk_i); done_i = 1'b1;
    @(negedge wb_clk_i); done_i = 1'b0;
  endtask

  typedef struct {
    int          done_at;
    logic [31:0] exp;
  } torn_vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          lat;
    logic        seen_ack;
    torn_vec_t   tv[6];

    tv[0] = '{4, 32'h8009_0006};  // one cycle after low capture
    tv[1] = '{0, 32'h0009_0006};  // on the accept edge, before the window
    tv[2] = '{3, 32'h8009_0006};  // on the low capture edge
    tv[3] = '{5, 32'h8009_0006};  // on the high capture edge
    tv[4] = '{6, 32'h0009_0006};  // on the ack edge, after the window
    tv[5] = '{2, 32'h0009_0006};  // one cycle before low capture

    #2 wb_rst_ni = 1'b0;
    #3;
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_scal_adr", 32'(scal_adr_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    repeat (2) @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;

    bus_read(7'h00, -1, d, lat);
    check("status_rst", d, 32'h6000_0000);
    check("status_lat", 32'(lat), 32'd1);

    bus_read(7'h40, -1, d, lat);
    check("pair40_dat", d, 32'h0003_0000);
    check("pair40_lat", 32'(lat), 32'd6);

    bus_read(7'h6F, -1, d, lat);
    check("pair6f_dat", d, 32'h011D_011A);
    check("pair6f_lat", 32'(lat), 32'd6);
    check("scal_adr_last", 32'(scal_adr_o), 32'h5F);

    bus_read(7'h70, -1, d, lat);
    check("oor70_dat", d, 32'd0);
    check("oor70_lat", 32'(lat), 32'd1);
    check("oor70_scal_adr", 32'(scal_adr_o), 32'h5F);

    bus_read(7'h10, -1, d, lat);
    check("unmapped10_dat", d, 32'd0);

    bus_write(7'h01, 32'h0000_0001, lat);
    check("ctrl_wr_lat", 32'(lat), 32'd1);
    bus_read(7'h01, -1, d, lat);
    check("ctrl_rd", d, 32'h0000_0001);

    repeat (3) pulse_done();
    repeat (2) @(posedge wb_clk_i);
    #1;
    check("irq_set", 32'(irq_o), 32'd1);
    bus_read(7'h00, -1, d, lat);
    check("status_3", d, 32'h6001_0003);
    check("irq_cleared", 32'(irq_o), 32'd0);

    bus_read(7'h00, 1, d, lat);
    check("status_race_dat", d, 32'h6000_0003);
    check("irq_race_kept", 32'(irq_o), 32'd1);
    bus_read(7'h00, -1, d, lat);
    check("status_race_after", d, 32'h6001_0004);

    foreach (tv[i]) begin
      bus_read(7'h41, tv[i].done_at, d, lat);
      check($sformatf("torn_%0d", tv[i].done_at), d, tv[i].exp);
    end
    bus_read(7'h00, -1, d, lat);
    check("status_after_torn", d, 32'h6001_000A);

    // Abort: cyc drops while the fetch waits on the low half.
    @(negedge wb_clk_i);
    wb_adr_i = 7'h41; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    seen_ack = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge wb_clk_i); #1;
      seen_ack = seen_ack | wb_ack_o;
    end
    check("abort_no_ack", 32'(seen_ack), 32'd0);
    check("abort_adr_hold", 32'(scal_adr_o), 32'h02);

    bus_read(7'h42, -1, d, lat);
    check("post_abort_dat", d, 32'h000F_000C);
    check("post_abort_lat", 32'(lat), 32'd6);

    // Async reset while the fetch sits in WAIT_HI.
    pulse_done();
    @(negedge wb_clk_i);
    wb_adr_i = 7'h40; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    repeat (5) @(posedge wb_clk_i);
    #2;
    check("pre_reset_irq", 32'(irq_o), 32'd1);
    wb_rst_ni = 1'b0;
    #1;
    check("midrst_ack", 32'(wb_ack_o), 32'd0);
    check("midrst_irq", 32'(irq_o), 32'd0);
    check("midrst_dat", wb_dat_o, 32'd0);
    check("midrst_scal_adr", 32'(scal_adr_o), 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;

    bus_read(7'h00, -1, d, lat);
    check("status_post_rst", d, 32'h6000_0000);
    bus_read(7'h01, -1, d, lat);
    check("ctrl_post_rst", d, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
